bit_stream_serializer: RTL and testbench
========================================

# bit_stream_serializer

Upstream feeder for the team's serial pattern-detector stages: accepts parallel words over a valid/ready handshake, buffers them in a small FIFO, and shifts them out one bit per enabled clock on a single-bit stream. Consecutive words stream with no idle gap, so a downstream detector sees a continuous bit sequence. `bit_valid` marks the cycles on which `bit_out` carries payload; downstream stages qualify their sampling with it.

## Interface
- DATA_W, 8, word width in bits; must be ≥ 2.
- FIFO_DEPTH, 4, word FIFO depth; must be a power of 2 and ≥ 2.
- MSB_FIRST, 1, 1 = bit DATA_W-1 is sent first; 0 = bit 0 is sent first.
- IDLE_BIT, 0, value driven on `bit_out` when no payload is present.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high.
- flush  in  1  synchronous clear of the FIFO and shifter.
- s_data  in  DATA_W  word to serialize.
- s_valid  in  1  `s_data` is valid.
- s_ready  out  1  the FIFO can accept a word.
- enable  in  1  bit-rate strobe; the shifter advances only on edges where this is 1.
- bit_out  out  1  serial data (registered).
- bit_valid  out  1  `bit_out` carries payload this cycle (registered).
- busy  out  1  shifter is in SHIFT or the FIFO is non-empty.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  number of words stored in the FIFO.

## Operation
- A push occurs on each edge where `s_valid && s_ready`.
- `s_ready = (fifo_level < FIFO_DEPTH) && !flush && !reset`. There is no pass-through when the FIFO is full.
- A push and a pop on the same edge leave `fifo_level` unchanged. Both pointers wrap modulo FIFO_DEPTH.
- Shifter state machine: IDLE and SHIFT. It holds the shift register `sr` and a remaining-bit counter `cnt` of width $clog2(DATA_W).
- **IDLE, enable=1, FIFO non-empty:**
  - Pop one word.
  - `bit_out` ← first bit, `bit_valid` ← 1.
  - `sr` ← the remaining bits, `cnt` ← DATA_W-1.
  - Go to SHIFT.
- **IDLE, otherwise:** `bit_out` ← IDLE_BIT, `bit_valid` ← 0.
- **SHIFT, enable=1, cnt > 0:** `bit_out` ← next bit of `sr`, `bit_valid` ← 1, `cnt` ← cnt-1.
- **SHIFT, enable=1, cnt = 0 (last bit is on the output):**
  - If the FIFO is non-empty: pop and load exactly as in IDLE, staying in SHIFT. This gives a gapless back-to-back stream.
  - Otherwise: `bit_out` ← IDLE_BIT, `bit_valid` ← 0, go to IDLE.
- **enable=0 (either state):**
  - `sr`, `cnt`, state and `bit_out` hold.
  - `bit_valid` ← 0, so a frozen bit is never presented as payload twice.
  - The FIFO still accepts pushes.
- **flush=1:**
  - Empties the FIFO (pointers and level to 0).
  - Shifter goes to IDLE, `bit_out` ← IDLE_BIT, `bit_valid` ← 0.
  - Any partially sent word is discarded.
  - Flush has priority over push, pop and enable.
- **Reset values:** state IDLE, `fifo_level` = 0, `bit_out` = IDLE_BIT, `bit_valid` = 0, `busy` = 0, `s_ready` = 0 while reset is high. After deassertion `s_ready` = 1.
- **Reset mid-word:** the word is lost with no partial output after release. The first push after release starts a fresh word.

## Timing
- Handshake to first bit, with enable held high and the shifter idle: word pushed at edge N; first bit on `bit_out` with `bit_valid` = 1 after edge N+1.
- A word occupies exactly DATA_W enabled edges on the output.
- Back-to-back words have zero idle cycles between them as long as the FIFO is non-empty when `cnt` = 0.
- `fifo_level` and `s_ready` update on the edge after the push or pop. `s_ready` drops in the cycle after the FIFO_DEPTH-th stored word.
- A pop frees a slot and `s_ready` rises in the following cycle.
- `busy` is combinational from state and `fifo_level`.

## Test plan
- **Single word:** push 0xB0 (MSB_FIRST=1), enable=1 → after edge N+1, `bit_out` = 1,0,1,1,0,0,0,0 over 8 cycles with `bit_valid` = 1. Then IDLE_BIT with `bit_valid` = 0, and `busy` falls.
- **Back-to-back:** push 0xB0 then 0x0B on consecutive edges → 16 contiguous valid bits 1011_0000_0000_1011 with no gap. `fifo_level` peaks at 1.
- **Full FIFO:** enable=0, push 5 words with s_valid held → 4 accepted, `s_ready` = 0, `fifo_level` = 4. Raise enable → `s_ready` returns one cycle after the first pop, and the 5th word is accepted.
- **Enable gaps:** push 0xA5 with enable toggling 1,0,1,0 → `bit_valid` pulses only on enabled edges. The valid bits read 1,0,1,0,0,1,0,1 with no repeats.
- **Flush:** flush asserted after 3 bits of 0xFF with 2 more words queued → next cycle `bit_valid` = 0, `fifo_level` = 0, `bit_out` = IDLE_BIT. A later push of 0x80 sends 1 followed by 0s from a fresh start.
- **Reset mid-word:** assert reset asynchronously mid-word → `bit_valid` = 0 and `bit_out` = IDLE_BIT immediately. After release the FIFO is empty and the next pushed word emits its full DATA_W bits.

Source files
------------

// File: rtl/bit_stream_serializer.sv
// bit_stream_serializer
//   Accepts parallel words over a valid/ready handshake and buffers them in
//   a small power-of-two FIFO. A shifter then emits them one bit per enabled
//   clock. Consecutive words stream with no idle gap.
//
// Ports
//   clk        : clock, rising edge
//   reset      : asynchronous, active-high
//   flush      : synchronous clear of FIFO and shifter (highest priority)
//   s_data     : word to serialize
//   s_valid    : s_data is valid
//   s_ready    : FIFO can accept a word
//   enable     : bit-rate strobe; shifter advances only when high
//   bit_out    : serial data (registered)
//   bit_valid  : bit_out carries payload this cycle (registered)
//   busy       : shifter active or FIFO non-empty
//   fifo_level : number of words held in the FIFO
module bit_stream_serializer #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter bit          IDLE_BIT   = 1'b0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic [DATA_W-1:0]             s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic                          enable,
    output logic                          bit_out,
    output logic                          bit_valid,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned CW = $clog2(DATA_W);
    localparam logic [LW-1:0] DEPTH_L  = LW'(FIFO_DEPTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(DATA_W - 1);

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    // FIFO storage and pointers
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q,  level_d;

    // Shifter
    state_t            state_q, state_d;
    logic [DATA_W-1:0] sr_q, sr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              bit_out_q, bit_out_d;
    logic              bit_valid_q, bit_valid_d;

    logic              push;
    logic              pop;
    logic              load;
    logic              fifo_nonempty;
    logic [DATA_W-1:0] head;

    assign s_ready       = (level_q < DEPTH_L) && !flush && !reset;
    assign push          = s_valid && s_ready;
    assign fifo_nonempty = (level_q != '0);
    assign head          = mem_q[rd_ptr_q];

    assign bit_out    = bit_out_q;
    assign bit_valid  = bit_valid_q;
    assign fifo_level = level_q;
    assign busy       = (state_q == S_SHIFT) || fifo_nonempty;

    // FIFO pointer/level next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // Shifter next-state. A load (pop + first bit) happens from IDLE or when
    // the last bit of the current word is on the output, which keeps
    // back-to-back words gapless.
    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        bit_out_d   = bit_out_q;
        bit_valid_d = 1'b0;
        pop         = 1'b0;
        load        = 1'b0;
        if (flush) begin
            state_d   = S_IDLE;
            bit_out_d = IDLE_BIT;
        end else if (enable) begin
            case (state_q)
                S_IDLE: begin
                    if (fifo_nonempty) load = 1'b1;
                    else               bit_out_d = IDLE_BIT;
                end
                S_SHIFT: begin
                    if (cnt_q != '0) begin
                        bit_out_d   = MSB_FIRST ? sr_q[DATA_W-1] : sr_q[0];
                        sr_d        = MSB_FIRST ? (sr_q << 1) : (sr_q >> 1);
                        cnt_d       = cnt_q - CW'(1);
                        bit_valid_d = 1'b1;
                    end else if (fifo_nonempty) begin
                        load = 1'b1;
                    end else begin
                        bit_out_d = IDLE_BIT;
                        state_d   = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
            if (load) begin
                pop         = 1'b1;
                state_d     = S_SHIFT;
                bit_valid_d = 1'b1;
                cnt_d       = LAST_CNT;
                bit_out_d   = MSB_FIRST ? head[DATA_W-1] : head[0];
                sr_d        = MSB_FIRST ? (head << 1) : (head >> 1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            state_q     <= S_IDLE;
            sr_q        <= '0;
            cnt_q       <= '0;
            bit_out_q   <= IDLE_BIT;
            bit_valid_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            state_q     <= state_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            bit_out_q   <= bit_out_d;
            bit_valid_q <= bit_valid_d;
        end
    end

    // Storage needs no reset: entries are only read when level says so.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= s_data;
    end

endmodule

// File: tb/tb_bit_stream_serializer.sv
module tb_bit_stream_serializer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       flush = 1'b0;
    logic [7:0] s_data = '0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic       enable = 1'b0;
    logic       bit_out;
    logic       bit_valid;
    logic       busy;
    logic [2:0] fifo_level;

    bit_stream_serializer #(
        .DATA_W    (8),
        .FIFO_DEPTH(4),
        .MSB_FIRST (1'b1),
        .IDLE_BIT  (1'b0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .enable    (enable),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .busy      (busy),
        .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad = 0;
    int   nvalid = 0;
    int   peak = 0;
    logic sb[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer: every payload bit must match the next expected bit.
    always @(negedge clk) begin
        if (!reset) begin
            if (int'(fifo_level) > peak) peak = int'(fifo_level);
            if (bit_valid) begin
                nvalid++;
                if (sb.size() == 0) check_eq("extra_bit", 32'd1, 32'd0);
                else                check_eq("bit", {31'd0, bit_out}, {31'd0, sb.pop_front()});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Holds s_valid until accepted; expected bits enter the scoreboard at the
    // accepting edge. Returns 1ns after that edge with s_valid still high.
    task automatic push_word(input logic [7:0] w, output int waited);
        logic acc;
        s_data  = w;
        s_valid = 1'b1;
        waited  = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            acc = s_ready;
            @(posedge clk);
            if (acc) begin
                for (int b = 7; b >= 0; b--) sb.push_back(w[b]);
                #1;
                return;
            end
            waited++;
        end
        check_eq("push_timeout", 32'd0, 32'd1);
        #1;
    endtask

    task automatic drain();
        int k;
        for (k = 0; k < 300; k++) begin
            @(negedge clk);
            if (!busy && !bit_valid) break;
        end
        if (k == 300) check_eq("drain_timeout", 32'd0, 32'd1);
        check_eq("sb_empty", sb.size(), 32'd0);
        tick(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        int n0;
        int run;

        // Reset state
        #12;
        check_eq("rst_bit_valid", {31'd0, bit_valid}, 32'd0);
        check_eq("rst_bit_out", {31'd0, bit_out}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_level", {29'd0, fifo_level}, 32'd0);
        check_eq("rst_ready", {31'd0, s_ready}, 32'd0);
        tick(2);
        reset = 1'b0;
        #1;
        check_eq("ready_after_rst", {31'd0, s_ready}, 32'd1);
        tick(1);

        // Single word, latency N+1
        enable = 1'b1;
        n0 = nvalid;
        push_word(8'hB0, w);
        s_valid = 1'b0;
        check_eq("lat_pre", {31'd0, bit_valid}, 32'd0);
        tick(1);
        check_eq("lat_first_valid", {31'd0, bit_valid}, 32'd1);
        check_eq("lat_first_bit", {31'd0, bit_out}, 32'd1);
        tick(9);
        check_eq("single_busy", {31'd0, busy}, 32'd0);
        check_eq("single_valid", {31'd0, bit_valid}, 32'd0);
        check_eq("single_idle_bit", {31'd0, bit_out}, 32'd0);
        check_eq("single_count", nvalid - n0, 32'd8);

        // Back-to-back, gapless
        n0   = nvalid;
        peak = 0;
        push_word(8'hB0, w);
        push_word(8'h0B, w);
        s_valid = 1'b0;
        run = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bit_valid) run++;
            else if (run > 0) break;
        end
        check_eq("b2b_run", run, 32'd16);
        check_eq("b2b_peak", peak, 32'd1);
        drain();

        // Full FIFO
        enable = 1'b0;
        push_word(8'h11, w);
        push_word(8'h22, w);
        push_word(8'h33, w);
        push_word(8'h44, w);
        s_data = 8'h55;
        check_eq("full_ready", {31'd0, s_ready}, 32'd0);
        check_eq("full_level", {29'd0, fifo_level}, 32'd4);
        tick(3);
        check_eq("full_hold_level", {29'd0, fifo_level}, 32'd4);
        enable = 1'b1;
        push_word(8'h55, w);
        s_valid = 1'b0;
        check_eq("ready_return_wait", w, 32'd1);
        check_eq("full_level_after", {29'd0, fifo_level}, 32'd4);
        drain();

        // Enable gaps
        enable = 1'b0;
        push_word(8'hA5, w);
        s_valid = 1'b0;
        n0 = nvalid;
        for (int i = 0; i < 16; i++) begin
            enable = (i % 2 == 0);
            tick(1);
            check_eq("vld_gate", {31'd0, bit_valid}, {31'd0, enable});
        end
        enable = 1'b1;
        drain();
        check_eq("gap_count", nvalid - n0, 32'd8);

        // Flush mid-word with words queued
        n0 = nvalid;
        push_word(8'hFF, w);
        push_word(8'h12, w);
        push_word(8'h34, w);
        s_valid = 1'b0;
        tick(1);
        flush = 1'b1;
        #1;
        check_eq("flush_ready", {31'd0, s_ready}, 32'd0);
        tick(1);
        check_eq("flush_bits", nvalid - n0, 32'd3);
        check_eq("flush_valid", {31'd0, bit_valid}, 32'd0);
        check_eq("flush_level", {29'd0, fifo_level}, 32'd0);
        check_eq("flush_bit_out", {31'd0, bit_out}, 32'd0);
        check_eq("flush_busy", {31'd0, busy}, 32'd0);
        flush = 1'b0;
        sb.delete();
        n0 = nvalid;
        push_word(8'h80, w);
        s_valid = 1'b0;
        drain();
        check_eq("post_flush_count", nvalid - n0, 32'd8);

        // Asynchronous reset mid-word
        push_word(8'hC3, w);
        s_valid = 1'b0;
        tick(3);
        #2;
        reset = 1'b1;
        #1;
        check_eq("arst_valid", {31'd0, bit_valid}, 32'd0);
        check_eq("arst_bit_out", {31'd0, bit_out}, 32'd0);
        check_eq("arst_level", {29'd0, fifo_level}, 32'd0);
        check_eq("arst_busy", {31'd0, busy}, 32'd0);
        check_eq("arst_ready", {31'd0, s_ready}, 32'd0);
        sb.delete();
        tick(2);
        reset = 1'b0;
        #1;
        check_eq("arst_ready_rel", {31'd0, s_ready}, 32'd1);
        n0 = nvalid;
        push_word(8'h5A, w);
        s_valid = 1'b0;
        drain();
        check_eq("post_rst_count", nvalid - n0, 32'd8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
